// File: rtl/mem_types.sv
// Shared types for the MEM-stage data port: FSM states, RV32I load/store funct3 codes,
// access sizes and byte-enable patterns.
package mem_types;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [3:0] MBE_B = 4'b0001;
  localparam logic [3:0] MBE_H = 4'b0011;
  localparam logic [3:0] MBE_W = 4'b1111;

  // Unknown funct3 encodings fall through to a word access.
  function automatic size_t access_size(input logic is_load, input logic [2:0] funct3);
    size_t sz;
    sz = SZ_W;
    if (is_load) begin
      case (funct3)
        lb, lbu: sz = SZ_B;
        lh, lhu: sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (funct3)
        sb:      sz = SZ_B;
        sh:      sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] offset);
    return ((sz == SZ_W) && (offset != 2'b00)) || ((sz == SZ_H) && offset[0]);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: replicated store data and byte enables, plus
// load lane extraction with sign/zero extension.
module mem_align
  import mem_types::*;
(
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  mbe,
  output logic [31:0] rdata
);

  size_t       sz;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    sz        = access_size(is_load, funct3);
    byte_lane = load_word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? load_word[31:16] : load_word[15:0];

    case (sz)
      SZ_B:    mbe = MBE_B << offset;
      SZ_H:    mbe = MBE_H << offset;
      default: mbe = MBE_W;
    endcase

    wdata = 32'h0;
    if (!is_load) begin
      case (sz)
        SZ_B:    wdata = {4{store_data[7:0]}};
        SZ_H:    wdata = {2{store_data[15:0]}};
        default: wdata = store_data;
      endcase
    end

    case (funct3)
      lb:      rdata = {{24{byte_lane[7]}}, byte_lane};
      lbu:     rdata = {24'h0, byte_lane};
      lh:      rdata = {{16{half_lane[15]}}, half_lane};
      lhu:     rdata = {16'h0, half_lane};
      default: rdata = load_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-port initiator: IDLE/ACCESS/DONE handshake with dmem, pipeline stall,
// alignment rejection and a response watchdog.
module mem_access_unit
  import mem_types::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [29:0]     acc_word;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_mbe;
  logic [2:0]      acc_funct3;
  logic [1:0]      acc_offset;
  logic            acc_load;

  logic        mem_req, req_load, req_misaligned, accept, expire;
  logic [31:0] req_wdata, ld_data, st_rdata_unused, ld_wdata_unused;
  logic [3:0]  req_mbe, ld_mbe_unused;

  assign mem_req        = req_valid && (mem_read || mem_write);
  assign req_load       = mem_read;  // read+write together is treated as a load
  assign req_misaligned = mem_req && is_misaligned(access_size(req_load, funct3), addr[1:0]);
  assign accept         = mem_req && !req_misaligned;
  assign expire         = (cnt == CNT_LAST) && !dmem_resp;

  mem_align u_store_align (
    .is_load    (req_load),
    .funct3     (funct3),
    .offset     (addr[1:0]),
    .store_data (store_data),
    .load_word  (32'h0),
    .wdata      (req_wdata),
    .mbe        (req_mbe),
    .rdata      (st_rdata_unused)
  );

  mem_align u_load_align (
    .is_load    (1'b1),
    .funct3     (acc_funct3),
    .offset     (acc_offset),
    .store_data (32'h0),
    .load_word  (dmem_rdata),
    .wdata      (ld_wdata_unused),
    .mbe        (ld_mbe_unused),
    .rdata      (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (dmem_resp || expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even though IDLE decodes live inputs.
  always_comb begin
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = 32'h0;
    dmem_wdata   = 32'h0;
    dmem_mbe     = 4'h0;
    mem_stall    = 1'b0;
    misaligned   = 1'b0;
    timeout      = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          mem_stall  = accept;
          misaligned = req_misaligned;
        end
        ACCESS: begin
          dmem_read    = acc_load;
          dmem_write   = !acc_load;
          dmem_address = {acc_word, 2'b00};
          dmem_wdata   = acc_wdata;
          dmem_mbe     = acc_mbe;
          mem_stall    = 1'b1;
          timeout      = expire;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      acc_word   <= '0;
      acc_wdata  <= '0;
      acc_mbe    <= '0;
      acc_funct3 <= '0;
      acc_offset <= '0;
      acc_load   <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      cnt <= (state == ACCESS && state_nxt == ACCESS) ? cnt + 1'b1 : '0;
      if (state == IDLE && accept) begin
        acc_word   <= addr[31:2];
        acc_wdata  <= req_wdata;
        acc_mbe    <= req_mbe;
        acc_funct3 <= funct3;
        acc_offset <= addr[1:0];
        acc_load   <= req_load;
      end
      if (state == ACCESS) begin
        if (dmem_resp) begin
          if (acc_load) mem_rdata <= ld_data;
        end else if (expire) begin
          mem_rdata <= '0;
        end
      end
    end
  end

  logic align_unused;
  assign align_unused = ^{st_rdata_unused, ld_wdata_unused, ld_mbe_unused};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short watchdog (TIMEOUT_CYCLES=4).
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic        dmem_resp = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_read, dmem_write, mem_stall, misaligned, timeout;
  logic [31:0] dmem_address, dmem_wdata, mem_rdata;
  logic [3:0]  dmem_mbe;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .misaligned(misaligned), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // resp_at = ACCESS cycle (1-based) carrying dmem_resp; 0 means never respond.
  task automatic do_access(input string tag, input logic ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input int resp_at,
                           input logic [31:0] rd, input logic [31:0] ex_addr,
                           input logic [31:0] ex_wdata, input logic [3:0] ex_mbe,
                           input logic [31:0] ex_rdata, input int ex_to);
    int stalls = 0, reqs = 0, tos = 0;
    bit done = 0;
    @(posedge clk) #1;
    req_valid = 1'b1; mem_read = ld; mem_write = !ld;
    funct3 = f3; addr = a; store_data = sd;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      if (cyc > 0) @(posedge clk) #1;
      dmem_resp  = (resp_at > 0) && (cyc == resp_at);
      dmem_rdata = dmem_resp ? rd : 32'h0;
      #5;
      if (timeout) tos++;
      if (dmem_read || dmem_write) begin
        reqs++;
        if (reqs == 1) begin
          chk({tag, "_addr"}, dmem_address, ex_addr);
          chk({tag, "_wdata"}, dmem_wdata, ex_wdata);
          chk({tag, "_mbe"}, {28'h0, dmem_mbe}, {28'h0, ex_mbe});
          chk({tag, "_dir"}, {31'h0, dmem_read}, {31'h0, ld});
        end
      end
      if (mem_stall) stalls++;
      else begin
        done = 1;
        chk({tag, "_rdata"}, mem_rdata, ex_rdata);
      end
    end
    chk({tag, "_budget"}, {31'h0, done}, 32'h1);
    chk({tag, "_stall"}, stalls, (resp_at > 0) ? resp_at + 1 : T + 1);
    chk({tag, "_reqs"}, reqs, (resp_at > 0) ? resp_at : T);
    chk({tag, "_timeout"}, tos, ex_to);
    @(posedge clk) #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic do_misaligned(input string tag, input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk) #1;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
    #5;
    chk({tag, "_pulse"}, {31'h0, misaligned}, 32'h1);
    chk({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
    chk({tag, "_noreq"}, {31'h0, dmem_read}, 32'h0);
    @(posedge clk) #1;
    req_valid = 1'b0; mem_read = 1'b0;
    #5;
    chk({tag, "_pulse_end"}, {31'h0, misaligned}, 32'h0);
    chk({tag, "_idle"}, {30'h0, mem_stall, dmem_read}, 32'h0);
  endtask

  initial begin
    #12;
    chk("rst_outs", {27'h0, dmem_read, dmem_write, mem_stall, misaligned, timeout}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    rst = 1'b1;

    do_access("lw",  1'b1, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'h100, 32'h0, 4'b1111, 32'hDEADBEEF, 0);
    do_access("lb",  1'b1, 3'b000, 32'h103, 32'h0, 1, 32'h80112233, 32'h100, 32'h0, 4'b1000, 32'hFFFFFF80, 0);
    do_access("lbu", 1'b1, 3'b100, 32'h103, 32'h0, 1, 32'h80112233, 32'h100, 32'h0, 4'b1000, 32'h00000080, 0);
    do_access("lh",  1'b1, 3'b001, 32'h102, 32'h0, 2, 32'h80112233, 32'h100, 32'h0, 4'b1100, 32'hFFFF8011, 0);
    do_access("lhu", 1'b1, 3'b101, 32'h102, 32'h0, 1, 32'h80112233, 32'h100, 32'h0, 4'b1100, 32'h00008011, 0);
    do_access("sb",  1'b0, 3'b000, 32'h201, 32'h000000AB, 2, 32'h0, 32'h200, 32'hABABABAB, 4'b0010, 32'h00008011, 0);
    do_access("sh",  1'b0, 3'b001, 32'h202, 32'h00001234, 1, 32'h0, 32'h200, 32'h12341234, 4'b1100, 32'h00008011, 0);
    do_access("sw",  1'b0, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h0, 32'h300, 32'hCAFEF00D, 4'b1111, 32'h00008011, 0);

    do_misaligned("mis_lw", 3'b010, 32'h102);
    do_misaligned("mis_lh", 3'b001, 32'h101);

    do_access("wdog",  1'b1, 3'b010, 32'h400, 32'h0, 0, 32'h0, 32'h400, 32'h0, 4'b1111, 32'h0, 1);
    do_access("coinc", 1'b1, 3'b010, 32'h404, 32'h0, T, 32'h12345678, 32'h404, 32'h0, 4'b1111, 32'h12345678, 0);

    // Reset in the second ACCESS cycle, then a late response while idle.
    @(posedge clk) #1;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h100;
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst = 1'b0;
    #1;
    chk("arst_read", {31'h0, dmem_read}, 32'h0);
    chk("arst_stall", {31'h0, mem_stall}, 32'h0);
    chk("arst_rdata", mem_rdata, 32'h0);
    req_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk) #1;
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk) #1;
    dmem_resp = 1'b0; rst = 1'b1;
    @(posedge clk) #1;
    dmem_resp = 1'b1;
    #4;
    chk("late_resp_idle", {30'h0, dmem_read, mem_stall}, 32'h0);
    chk("late_resp_rdata", mem_rdata, 32'h0);
    @(posedge clk) #1;
    dmem_resp = 1'b0;

    do_access("b2b", 1'b1, 3'b010, 32'h104, 32'h0, 1, 32'h0BADF00D, 32'h104, 32'h0, 4'b1111, 32'h0BADF00D, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-port initiator: converts the EX/MEM load/store request into a dmem read/write handshake.
- Returns an aligned, extended load result (mem_rdata) that the MEM/WB register captures.
- Produces mem_stall, which freezes the pipeline, including the MEM/WB load enable, until the access completes.
- Handles byte/half/word lane steering, misalignment detection and a response watchdog.

Parameters:
TIMEOUT_CYCLES, 64, cycles in ACCESS without dmem_resp before the access is abandoned (must be >=2)
CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  EX/MEM holds a valid instruction
mem_read  input  1  EX/MEM ctrl word: load
mem_write  input  1  EX/MEM ctrl word: store (mem_read && mem_write is illegal; treat as load)
funct3  input  3  load/store width/sign encoding from EX/MEM instruction
addr  input  32  EX/MEM alu_out (byte address)
store_data  input  32  EX/MEM rs2 value
dmem_resp  input  1  memory completion, single-cycle pulse
dmem_rdata  input  32  memory read word, valid with dmem_resp
dmem_read  output  1  read request, held until resp
dmem_write  output  1  write request, held until resp
dmem_address  output  32  {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_mbe  output  4  byte enables
mem_rdata  output  32  extended load result, to MEM/WB
mem_stall  output  1  hold pipeline (IF..MEM/WB loads deasserted)
misaligned  output  1  one-cycle pulse: request rejected for alignment
timeout  output  1  one-cycle pulse: watchdog expired

Behaviour:
- Reset (rst low, async): state IDLE, counter 0, all outputs 0, mem_rdata 0. Outputs drop immediately, even mid-ACCESS; no response is awaited afterwards, and a late dmem_resp in IDLE is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when req_valid && (mem_read||mem_write).
  - Misaligned (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0): pulse misaligned, no dmem request, mem_stall 0, stay IDLE.
  - Otherwise register address, wdata, mbe and funct3; go ACCESS.
  - mem_stall is combinationally 1 in the accepting cycle.
- ACCESS:
  - dmem_read or dmem_write = 1; address, wdata and mbe stable from registers; mem_stall 1; counter increments each cycle.
  - On dmem_resp: load → mem_rdata <= extend(dmem_rdata); go DONE.
  - If counter reaches TIMEOUT_CYCLES-1 without resp: drop request, pulse timeout, mem_rdata <= 0, go DONE.
  - dmem_resp and timeout in the same cycle: resp wins; no timeout pulse.
- DONE:
  - mem_stall 0 for exactly one cycle, so the pipeline and MEM/WB advance with mem_rdata valid; no request.
  - Unconditionally return to IDLE. The same EX/MEM contents seen in DONE are never re-issued.
  - mem_rdata holds until the next load completes.
- Latency: load/store with resp in the k-th ACCESS cycle → stall for k+1 cycles, data visible the cycle after resp.
- Store steering (o = addr[1:0]):
  - SB: wdata = {4{byte}}, mbe = 4'b0001<<o.
  - SH: wdata = {2{half}}, mbe = 4'b0011<<o.
  - SW: wdata as is, mbe = 4'b1111.
- Loads drive mbe the same as the matching width, and wdata 0.
- Load extend:
  - LB/LBU: byte lane o, sign/zero-extended.
  - LH/LHU: half at o[1], sign/zero-extended.
  - LW: full word.
- Undefined funct3: treated as a word access.
- Non-memory instruction, or req_valid 0: outputs idle, mem_stall 0.

Decomposition:
- Package mem_types: state enum (IDLE/ACCESS/DONE), load/store funct3 encodings (reuse rv32i_types load_funct3_t/store_funct3_t), mbe constants.
- Sub-module mem_align: purely combinational store steering (data, mbe) and load extraction/extension. It is instantiated once for store/mbe and once for load.
- The FSM and watchdog live in the top module.

Test Plan:
- LW addr 0x100, resp after 3 ACCESS cycles, rdata 0xDEADBEEF → dmem_address 0x100, mbe 1111, stall 4 cycles, mem_rdata 0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80112233 → mbe 1000, mem_rdata 0xFFFFFF80. LBU same → 0x00000080. LH addr 0x102 → 0xFFFF8011.
- SB addr 0x201, store_data 0x000000AB → dmem_write, dmem_address 0x200, wdata 0xABABABAB, mbe 0010. SH addr 0x202 data 0x1234 → wdata 0x12341234, mbe 1100.
- LW addr 0x102 → misaligned pulse, no dmem_read, mem_stall 0 throughout.
- No resp, TIMEOUT_CYCLES=4 → request dropped after 4 ACCESS cycles, timeout pulse, mem_rdata 0, DONE then IDLE. Separately, resp coincident with the last count → normal completion, no timeout.
- rst low in the 2nd ACCESS cycle → dmem_read 0 same cycle, state IDLE. A late resp is ignored. A back-to-back second load after release completes normally.
